// File: rtl/exec_pkg.sv
// Shared execute-stage definitions: architectural register indices, stack-op
// encoding and the stack sequencer state set.
package exec_pkg;

  localparam logic [4:0] REG_SP   = 5'd28;
  localparam logic [4:0] REG_PC   = 5'd30;
  localparam logic [4:0] REG_CPSR = 5'd31;

  typedef enum logic [2:0] {
    OP_PUSH = 3'b000,
    OP_POP  = 3'b001,
    OP_CALL = 3'b010,
    OP_RET  = 3'b011,
    OP_INT  = 3'b100
  } stack_op_e;

  typedef enum logic [3:0] {
    IDLE, RD_SP, CAP_SP, PUSH_W, POP_RD, POP_WB, SP_WB, INT1, INT2, BR, FAULT, ILL
  } seq_state_e;

  // True when pushing n words onto a full-descending stack at sp wraps or
  // lands below the lowest legal stack address.
  function automatic logic push_faults(input logic [15:0] sp, input logic [1:0] n,
                                       input logic [15:0] limit);
    logic [16:0] diff;
    diff = {1'b0, sp} - {15'b0, n};
    return diff[16] || (diff[15:0] < limit);
  endfunction

endpackage

// File: rtl/stack_sequencer.sv
// Multi-cycle sequencer for PUSH/POP/CALL/RET/INT; owns the register-file and
// data-memory ports while busy and redirects fetch through a one-cycle branch.
module stack_sequencer
  import exec_pkg::*;
#(
  parameter logic [15:0] IVT_BASE    = 16'hFF00,
  parameter logic [15:0] STACK_LIMIT = 16'h8000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [15:0] operand,
  input  logic [4:0]  dst_idx,
  input  logic [15:0] return_pc,
  output logic        busy,
  output logic        done,
  output logic        illegal,
  output logic        stack_fault,
  output logic        reg_r_en,
  output logic [4:0]  reg_r_idx,
  input  logic [15:0] reg_r_data,
  output logic        reg_w_en,
  output logic [4:0]  reg_w_idx,
  output logic [15:0] reg_w_data,
  output logic        mem_r_en,
  output logic [15:0] mem_r_addr,
  input  logic [15:0] mem_r_data,
  output logic        mem_w_en,
  output logic [15:0] mem_w_addr,
  output logic [15:0] mem_w_data,
  output logic        branch_en,
  output logic [15:0] branch_target,
  output seq_state_e  dbg_state_o
);

  // Handshake: start is sampled only in IDLE (busy=0); done pulses in the last
  // busy cycle and the next request may be accepted in the following cycle.
  seq_state_e  state_q, state_d;
  logic [2:0]  op_q;
  logic [15:0] operand_q;
  logic [4:0]  dst_q;
  logic [15:0] rpc_q;
  logic [15:0] sp_q;
  logic        accept;
  logic        cap_fault;

  assign accept      = (state_q == IDLE) && start;
  assign dbg_state_o = state_q;

  // reg_r_data holds SP during CAP_SP; the fault decision cannot wait for sp_q.
  always_comb begin
    cap_fault = 1'b0;
    case (op_q)
      OP_PUSH, OP_CALL: cap_fault = push_faults(reg_r_data, 2'd1, STACK_LIMIT);
      OP_INT:           cap_fault = push_faults(reg_r_data, 2'd2, STACK_LIMIT);
      OP_POP, OP_RET:   cap_fault = (reg_r_data == 16'hFFFF);
      default:          cap_fault = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      op_q      <= 3'b000;
      operand_q <= 16'h0000;
      dst_q     <= 5'd0;
      rpc_q     <= 16'h0000;
      sp_q      <= 16'h0000;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q      <= op;
        operand_q <= operand;
        dst_q     <= dst_idx;
        rpc_q     <= return_pc;
      end
      if (state_q == CAP_SP) sp_q <= reg_r_data;
    end
  end

  always_comb begin
    state_d       = state_q;
    busy          = (state_q != IDLE);
    done          = 1'b0;
    illegal       = 1'b0;
    stack_fault   = 1'b0;
    reg_r_en      = 1'b0;
    reg_r_idx     = 5'd0;
    reg_w_en      = 1'b0;
    reg_w_idx     = 5'd0;
    reg_w_data    = 16'h0000;
    mem_r_en      = 1'b0;
    mem_r_addr    = 16'h0000;
    mem_w_en      = 1'b0;
    mem_w_addr    = 16'h0000;
    mem_w_data    = 16'h0000;
    branch_en     = 1'b0;
    branch_target = 16'h0000;
    case (state_q)
      IDLE: if (start) state_d = (op > 3'(OP_INT)) ? ILL : RD_SP;
      RD_SP: begin
        reg_r_en  = 1'b1;
        reg_r_idx = REG_SP;
        state_d   = CAP_SP;
      end
      CAP_SP: begin
        if (cap_fault) state_d = FAULT;
        else begin
          case (op_q)
            OP_PUSH, OP_CALL: state_d = PUSH_W;
            OP_POP, OP_RET:   state_d = POP_RD;
            OP_INT:           state_d = INT1;
            default:          state_d = ILL;
          endcase
        end
      end
      PUSH_W: begin
        mem_w_en   = 1'b1;
        mem_w_addr = sp_q - 16'd1;
        mem_w_data = (op_q == OP_PUSH) ? operand_q : rpc_q;
        reg_w_en   = 1'b1;
        reg_w_idx  = REG_SP;
        reg_w_data = sp_q - 16'd1;
        if (op_q == OP_PUSH) begin
          done    = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = BR;
        end
      end
      POP_RD: begin
        mem_r_en   = 1'b1;
        mem_r_addr = sp_q;
        state_d    = (op_q == OP_RET) ? BR : POP_WB;
      end
      POP_WB: begin
        reg_w_en   = 1'b1;
        reg_w_idx  = dst_q;
        reg_w_data = mem_r_data;
        // Popping into SP: the popped value is the new SP, no increment.
        if (dst_q == REG_SP) begin
          done    = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = SP_WB;
        end
      end
      SP_WB: begin
        reg_w_en   = 1'b1;
        reg_w_idx  = REG_SP;
        reg_w_data = sp_q + 16'd1;
        done       = 1'b1;
        state_d    = IDLE;
      end
      INT1: begin
        mem_w_en   = 1'b1;
        mem_w_addr = sp_q - 16'd1;
        mem_w_data = rpc_q;
        reg_r_en   = 1'b1;
        reg_r_idx  = REG_CPSR;
        state_d    = INT2;
      end
      INT2: begin
        mem_w_en   = 1'b1;
        mem_w_addr = sp_q - 16'd2;
        mem_w_data = reg_r_data;
        reg_w_en   = 1'b1;
        reg_w_idx  = REG_SP;
        reg_w_data = sp_q - 16'd2;
        mem_r_en   = 1'b1;
        mem_r_addr = IVT_BASE + {12'h000, operand_q[3:0]};
        state_d    = BR;
      end
      BR: begin
        branch_en     = 1'b1;
        branch_target = (op_q == OP_CALL) ? operand_q : mem_r_data;
        if (op_q == OP_RET) begin
          reg_w_en   = 1'b1;
          reg_w_idx  = REG_SP;
          reg_w_data = sp_q + 16'd1;
        end
        done    = 1'b1;
        state_d = IDLE;
      end
      FAULT: begin
        stack_fault = 1'b1;
        done        = 1'b1;
        state_d     = IDLE;
      end
      ILL: begin
        illegal = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
